// File: rtl/ts_packet_fifo_pkg.sv
// Shared constants and write-FSM encoding for the TS packet FIFO.
`timescale 1ns/1ps
package ts_packet_fifo_pkg;
  localparam int unsigned TS_PKT_LEN   = 188;
  localparam logic [7:0]  TS_SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_FILL = 2'd1,
    WR_DROP = 2'd2
  } wr_state_t;
endpackage

// File: rtl/sync_dp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
`timescale 1ns/1ps
module sync_dp_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

  // rdata holds its value while re is low; the FIFO uses that as a holding stage
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/ts_packet_fifo.sv
// Packet FIFO for MPEG-TS: only whole PKT_LEN-byte packets become readable.
`timescale 1ns/1ps
module ts_packet_fifo
  import ts_packet_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned PKT_LEN      = TS_PKT_LEN,
  parameter int unsigned AFULL_THRESH = 2**ADDR_WIDTH - PKT_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_sop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic                  out_sop,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  almost_full,
  output logic [15:0]           drop_count
);
  localparam int unsigned PW = ADDR_WIDTH + 1;
  localparam int unsigned CW = $clog2(PKT_LEN + 1);
  localparam logic [PW-1:0] DEPTH_P  = PW'(2**ADDR_WIDTH);
  localparam logic [PW-1:0] AFULL_P  = PW'(AFULL_THRESH);
  localparam logic [CW-1:0] LAST_CNT = CW'(PKT_LEN - 1);

  if (2**ADDR_WIDTH < PKT_LEN) begin : g_depth_check
    $error("ts_packet_fifo: 2**ADDR_WIDTH must be >= PKT_LEN");
  end

  wr_state_t             state, state_n;
  logic [PW-1:0]         wr_ptr, wr_ptr_n, wr_commit, wr_commit_n;
  logic [PW-1:0]         rd_ptr, snk_ptr;
  logic [CW-1:0]         cnt, cnt_n, rd_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic                  we, drop_inc, ram_full, commit_full;
  logic                  re, ram_vld, load_out, out_fire;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign ram_full    = (wr_ptr - rd_ptr) == DEPTH_P;
  assign commit_full = (wr_commit - rd_ptr) == DEPTH_P;

  always_comb begin
    state_n     = state;
    wr_ptr_n    = wr_ptr;
    wr_commit_n = wr_commit;
    cnt_n       = cnt;
    wr_addr     = wr_ptr[ADDR_WIDTH-1:0];
    we          = 1'b0;
    drop_inc    = 1'b0;
    case (state)
      WR_FILL: begin
        if (in_valid && in_sop) begin
          // early sync: abandon the partial packet and restart at wr_commit
          drop_inc = 1'b1;
          if (commit_full) begin
            wr_ptr_n = wr_commit;
            cnt_n    = '0;
            state_n  = WR_DROP;
          end else begin
            we       = 1'b1;
            wr_addr  = wr_commit[ADDR_WIDTH-1:0];
            wr_ptr_n = wr_commit + PW'(1);
            cnt_n    = CW'(1);
          end
        end else if (in_valid) begin
          if (ram_full) begin
            drop_inc = 1'b1;
            wr_ptr_n = wr_commit;
            cnt_n    = '0;
            state_n  = WR_DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + PW'(1);
            if (cnt == LAST_CNT) begin
              wr_commit_n = wr_ptr + PW'(1);
              cnt_n       = '0;
              state_n     = WR_IDLE;
            end else begin
              cnt_n = cnt + CW'(1);
            end
          end
        end
      end
      default: begin
        if (in_valid && in_sop) begin
          if (ram_full) begin
            drop_inc = 1'b1;
            wr_ptr_n = wr_commit;
            state_n  = WR_DROP;
          end else begin
            we       = 1'b1;
            wr_ptr_n = wr_ptr + PW'(1);
            cnt_n    = CW'(1);
            state_n  = WR_FILL;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WR_IDLE;
      wr_ptr     <= '0;
      wr_commit  <= '0;
      cnt        <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_n;
      wr_ptr    <= wr_ptr_n;
      wr_commit <= wr_commit_n;
      cnt       <= cnt_n;
      if (drop_inc && drop_count != '1) drop_count <= drop_count + 16'd1;
    end
  end

  // Two-stage read pipeline: RAM read register, then output register.
  assign out_fire = out_valid && out_ready;
  assign load_out = ram_vld && (!out_valid || out_ready);
  assign re       = (rd_ptr != wr_commit) && (!ram_vld || load_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      snk_ptr   <= '0;
      rd_cnt    <= '0;
      ram_vld   <= 1'b0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_data  <= '0;
    end else begin
      if (re) rd_ptr <= rd_ptr + PW'(1);
      if (out_fire) snk_ptr <= snk_ptr + PW'(1);
      if (re) ram_vld <= 1'b1;
      else if (load_out) ram_vld <= 1'b0;
      if (load_out) begin
        out_valid <= 1'b1;
        out_data  <= ram_rdata;
        out_sop   <= (rd_cnt == '0);
        rd_cnt    <= (rd_cnt == LAST_CNT) ? '0 : rd_cnt + CW'(1);
      end else if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

  // level counts committed bytes the sink has not yet taken
  assign level       = wr_commit - snk_ptr;
  assign almost_full = level >= AFULL_P;

  sync_dp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk  (clk),
    .we   (we),
    .waddr(wr_addr),
    .wdata(in_data),
    .re   (re),
    .raddr(rd_ptr[ADDR_WIDTH-1:0]),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_ts_packet_fifo.sv
// Scoreboard bench for ts_packet_fifo: packet-level reference model, decoupled monitor.
`timescale 1ns/1ps
module tb_ts_packet_fifo;
  import ts_packet_fifo_pkg::*;

  localparam int unsigned DW    = 8;
  localparam int unsigned AW    = 9;
  localparam int unsigned PL    = TS_PKT_LEN;
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned AF    = DEPTH - PL;

  logic          clk, rst;
  logic [DW-1:0] in_data, out_data;
  logic          in_valid, in_sop, out_valid, out_sop, out_ready;
  logic [AW:0]   level;
  logic          almost_full;
  logic [15:0]   drop_count;

  ts_packet_fifo #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .PKT_LEN(PL)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_ready(out_ready), .level(level), .almost_full(almost_full),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic s; } exp_t;
  exp_t exp_q[$];

  int  checks = 0;
  int  failures = 0;
  int  model_drop = 0;
  bit  model_open = 1'b0;
  bit  rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted byte and checks stall stability
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_sop;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else if (out_valid) begin
      if (prev_stall) begin
        check("stall_data", 32'(out_data), 32'(prev_data));
        check("stall_sop", 32'(out_sop), 32'(prev_sop));
      end
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h sop %0b expected none at %0t", out_data, out_sop, $time);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("out_data", 32'(out_data), 32'(e.d));
          check("out_sop", 32'(out_sop), 32'(e.s));
        end
      end
      prev_stall = !out_ready;
      prev_data  = out_data;
      prev_sop   = out_sop;
    end else begin
      if (prev_stall) check("valid_held", 32'(out_valid), 32'd1);
      prev_stall = 1'b0;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] d, input logic s, input logic v);
    in_data  = d;
    in_sop   = s;
    in_valid = v;
    tick();
  endtask

  // Packet-level model: an sop while a packet is open drops it; a whole packet
  // is kept only if it fits alongside the bytes the sink has not yet taken.
  task automatic send_pkt(input int len, input int gap_pct);
    exp_t buf_q[$];
    bit   fits;
    if (model_open) model_drop++;
    fits = (exp_q.size() + PL) <= DEPTH;
    for (int i = 0; i < len; i++) begin
      logic [7:0] b;
      b = (i == 0) ? TS_SYNC_BYTE : 8'($urandom);
      buf_q.push_back('{d: b, s: (i == 0)});
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) drive(8'($urandom), 1'b0, 1'b0);
      drive(b, i == 0, 1'b1);
    end
    in_valid = 1'b0;
    in_sop   = 1'b0;
    if (len == int'(PL)) begin
      model_open = 1'b0;
      if (fits) foreach (buf_q[k]) exp_q.push_back(buf_q[k]);
      else model_drop++;
    end else begin
      model_open = 1'b1;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
    @(negedge clk);
    check("idle_out_valid", 32'(out_valid), 32'd0);
    check("idle_level", 32'(level), 32'd0);
    check("drop_count", 32'(drop_count), 32'(model_drop));
    tick();
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sop", 32'(out_sop), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_almost_full", 32'(almost_full), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Latency from commit edge to out_valid on an empty FIFO
    out_ready = 1'b1;
    send_pkt(PL, 0);
    @(negedge clk);
    check("lat_edge0", 32'(out_valid), 32'd0);
    tick(); @(negedge clk);
    check("lat_edge1", 32'(out_valid), 32'd0);
    tick(); @(negedge clk);
    check("lat_edge2", 32'(out_valid), 32'd1);
    tick();
    wait_drain(1000);

    // Three back-to-back packets, sink always ready
    for (int p = 0; p < 3; p++) send_pkt(PL, 0);
    wait_drain(1000);

    // Stray non-sop bytes in IDLE are ignored
    for (int i = 0; i < 20; i++) drive(8'($urandom), 1'b0, 1'b1);
    send_pkt(PL, 0);
    wait_drain(1000);

    // Short packet followed by a full one: short one dropped
    send_pkt(100, 0);
    send_pkt(PL, 0);
    wait_drain(1000);

    // Overflow with sink stalled: third packet dropped
    out_ready = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(PL, 0);
    repeat (4) tick();
    @(negedge clk);
    check("ovf_level", 32'(level), 32'(exp_q.size()));
    check("ovf_level_abs", 32'(level), 32'(2 * PL));
    check("ovf_almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
    check("ovf_drop_count", 32'(drop_count), 32'(model_drop));
    tick();
    out_ready = 1'b1;
    wait_drain(1000);

    // Random sink backpressure and random input gaps
    rand_ready = 1'b1;
    for (int p = 0; p < 10; p++) begin
      int n = 0;
      while (level > 128 && n < 2000) begin tick(); n++; end
      check("rand_level_wait", 32'(level > 128), 32'd0);
      send_pkt(PL, 30);
    end
    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 4000) begin tick(); n++; end
    end
    rand_ready = 1'b0;
    tick();
    out_ready = 1'b1;
    wait_drain(1000);

    // Reset in the middle of the second packet
    send_pkt(PL, 0);
    for (int i = 0; i < 90; i++) drive((i == 0) ? TS_SYNC_BYTE : 8'($urandom), i == 0, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    in_sop = 1'b0;
    exp_q.delete();
    model_open = 1'b0;
    model_drop = 0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sop", 32'(out_sop), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_almost_full", 32'(almost_full), 32'd0);
    check("mid_rst_drop_count", 32'(drop_count), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    send_pkt(PL, 0);
    wait_drain(1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
